// File: rtl/operand_fwd.sv
// rtl/operand_fwd.sv - operand forwarding tracker with load-use stall detection (optional OPERAND_FWD_STAT_EN stall counter)
module operand_fwd #(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef OPERAND_FWD_STAT_EN
  output logic [31:0]             stall_cnt_o,
`endif
  input  logic [NUM_SRC*5-1:0]    src_idx_i,
  input  logic [NUM_SRC*2-1:0]    src_sel_i,
  input  logic [NUM_SRC*XLEN-1:0] rf_data_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic                    issue_valid_i,
  input  logic                    wr_valid_i,
  input  logic [4:0]              wr_rd_i,
  input  logic                    wr_is_load_i,
  input  logic [XLEN-1:0]         wr_data_i,
  input  logic [XLEN-1:0]         mem_rdata_i,
  output logic [NUM_SRC*XLEN-1:0] opnd_o,
  output logic [NUM_SRC-1:0]      fwd_hit_o,
  output logic                    stall_o
);

  // Tracker entries, index 0 is the youngest writer.
  logic [FWD_DEPTH-1:0]           r_valid;
  logic [FWD_DEPTH-1:0][4:0]      r_rd;
  logic [FWD_DEPTH-1:0]           r_dvalid;
  logic [FWD_DEPTH-1:0][XLEN-1:0] r_data;

  logic [NUM_SRC-1:0]             w_port_stall;

  // Shift the tracker every cycle; a pending load picks up memory data as it leaves entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_rd     <= '0;
      r_dvalid <= '0;
      r_data   <= '0;
    end else begin
      r_valid[0]  <= wr_valid_i;
      r_rd[0]     <= wr_rd_i;
      r_dvalid[0] <= !wr_is_load_i;
      r_data[0]   <= wr_data_i;

      r_valid[1] <= r_valid[0];
      r_rd[1]    <= r_rd[0];
      if (r_valid[0] && !r_dvalid[0]) begin
        r_dvalid[1] <= 1'b1;
        r_data[1]   <= mem_rdata_i;
      end else begin
        r_dvalid[1] <= r_dvalid[0];
        r_data[1]   <= r_data[0];
      end

      for (int i = 2; i < FWD_DEPTH; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_rd[i]     <= r_rd[i-1];
        r_dvalid[i] <= r_dvalid[i-1];
        r_data[i]   <= r_data[i-1];
      end
    end
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    logic [4:0]      w_idx;
    logic [1:0]      w_sel;
    logic [XLEN-1:0] w_rf;
    logic            w_imm_sel;
    logic            w_match_any;
    logic            w_match_dv;
    logic [XLEN-1:0] w_match_data;

    assign w_idx     = src_idx_i[p*5 +: 5];
    assign w_sel     = src_sel_i[p*2 +: 2];
    assign w_rf      = rf_data_i[p*XLEN +: XLEN];
    assign w_imm_sel = (w_sel == 2'b01);

    // Scan oldest to youngest so the youngest matching entry overrides older ones; x0 never matches.
    always_comb begin
      w_match_any  = 1'b0;
      w_match_dv   = 1'b1;
      w_match_data = w_rf;
      for (int e = FWD_DEPTH - 1; e >= 0; e--) begin
        if (r_valid[e] && (r_rd[e] == w_idx) && (w_idx != 5'd0)) begin
          w_match_any  = 1'b1;
          w_match_dv   = r_dvalid[e];
          w_match_data = r_data[e];
        end
      end
    end

    assign opnd_o[p*XLEN +: XLEN] = w_imm_sel ? imm_i : w_match_data;
    assign fwd_hit_o[p]           = !w_imm_sel && w_match_any;
    assign w_port_stall[p]        = !w_imm_sel && w_match_any && !w_match_dv;
  end

  assign stall_o = issue_valid_i && (|w_port_stall);

`ifdef OPERAND_FWD_STAT_EN
  logic [31:0] r_stall_cnt;

  // Count stalled cycles, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/operand_fwd.md
OPERAND_FWD -- requirements
Module: operand_fwd

Interface
REQ-001 Parameter XLEN, default 32: operand and data width in bits.
REQ-002 Parameter NUM_SRC, default 2, range 1..4: number of independent operand ports.
REQ-003 Parameter FWD_DEPTH, default 3, range 2..4: number of tracked in-flight writer stages (entry 0 youngest).
REQ-004 clk  in  1  single core clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 src_idx_i  in  NUM_SRC*5  architectural source register index per port.
REQ-007 src_sel_i  in  NUM_SRC*2  per-port source select: 00 register path, 01 immediate, others treated as 00.
REQ-008 rf_data_i  in  NUM_SRC*XLEN  register-file read data per port.
REQ-009 imm_i  in  XLEN  decoded immediate, shared by all ports.
REQ-010 issue_valid_i  in  1  an instruction is presented for issue.
REQ-011 wr_valid_i  in  1  the instruction leaving EX writes a register.
REQ-012 wr_rd_i  in  5  destination index of that writer.
REQ-013 wr_is_load_i  in  1  the writer is a load; its data is not yet known.
REQ-014 wr_data_i  in  XLEN  ALU result of the writer (ignored for loads).
REQ-015 mem_rdata_i  in  XLEN  load data, valid for the load currently in entry 0.
REQ-016 opnd_o  out  NUM_SRC*XLEN  selected operand per port.
REQ-017 fwd_hit_o  out  NUM_SRC  port operand was taken from a tracked entry.
REQ-018 stall_o  out  1  issue blocked by load-use hazard; issue_ready = !stall_o.

Function
REQ-019 Tracker SHALL hold FWD_DEPTH entries {valid, rd[4:0], dvalid, data[XLEN-1:0]}.
REQ-020 Every clock entries SHALL shift one place (i -> i+1); entry FWD_DEPTH-1 is discarded.
REQ-021 Entry 0 SHALL load {wr_valid_i, wr_rd_i, !wr_is_load_i, wr_data_i}; wr_valid_i=0 loads an invalid entry.
REQ-022 When a valid entry 0 with dvalid=0 shifts into entry 1, entry 1 SHALL capture mem_rdata_i and set dvalid=1 (fixed one-cycle load latency).
REQ-023 Port match: entry valid, rd equals src_idx, src_idx != 0; x0 SHALL never match and opnd_o SHALL return rf_data_i for x0.
REQ-024 For select 01 opnd_o SHALL equal imm_i, fwd_hit_o=0, port never stalls.
REQ-025 For register path the lowest-index (youngest) matching entry SHALL win; opnd_o = its data, fwd_hit_o=1; no match -> rf_data_i, fwd_hit_o=0.
REQ-026 stall_o SHALL be 1 iff issue_valid_i=1 and any register-path port's youngest match has dvalid=0; older dvalid=1 matches SHALL not mask it.
REQ-027 opnd_o, fwd_hit_o, stall_o SHALL be combinational from tracker state and current inputs (zero latency).
REQ-028 Upstream drives wr_valid_i=0 during a stall cycle; tracker shifting is not gated by stall_o.
REQ-029 Same-cycle write and read of one index SHALL see the tracker contents before the edge (new writer visible next cycle).

Reset
REQ-030 rst_n low SHALL clear all entry valid and dvalid bits and data to 0 immediately, independent of clk.
REQ-031 During and after reset until first write: stall_o=0, fwd_hit_o=0, opnd_o equals rf_data_i/imm_i per select.
REQ-032 Reset asserted mid-load SHALL drop the pending load; no stall after release.

Configuration
REQ-033 Macro OPERAND_FWD_STAT_EN defined: adds output stall_cnt_o [31:0], reset 0, incrementing each cycle stall_o=1, saturating at 0xFFFF_FFFF.
REQ-034 Macro undefined: stall_cnt_o and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-035 Write x5=0x1234 (ALU), next cycle read x5 on port0 -> opnd_o[0]=0x1234, fwd_hit_o[0]=1, stall_o=0.
REQ-036 Writes x7=0xA then x7=0xB on consecutive cycles, read x7 -> opnd_o=0xB (youngest wins).
REQ-037 Load to x3, read x3 next cycle -> stall_o=1 one cycle; mem_rdata_i=0xDEAD captured; following cycle opnd_o=0xDEAD, stall_o=0.
REQ-038 Write x0=0x55, read x0 with rf_data_i=0 -> opnd_o=0, fwd_hit_o=0; select 01 with imm_i=0x7FF -> opnd_o=0x7FF.
REQ-039 Write x9, then FWD_DEPTH idle cycles, read x9 -> fwd_hit_o=0, opnd_o=rf_data_i.
REQ-040 Load pending, assert rst_n=0 one cycle, read target -> stall_o=0; with OPERAND_FWD_STAT_EN, stall_cnt_o counts stalls and returns to 0 on reset.
